// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: state encoding, byte/column types and GF(2^8) helpers for AES decryption steps
package aes_dec_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_RD0  = 3'd1;
  localparam state_t S_RD1  = 3'd2;
  localparam state_t S_RDW  = 3'd3;
  localparam state_t S_WR0  = 3'd4;
  localparam state_t S_WR1  = 3'd5;
  localparam state_t S_DONE = 3'd6;
  typedef logic [7:0] byte_t;
  typedef byte_t [3:0] col_t;
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // Constants 09/0b/0d/0e only need the x, x^2, x^3 multiples.
  function automatic byte_t gmul(input byte_t b, input logic [3:0] c);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction
endpackage

// File: rtl/inv_mixcolumn_addroundkey_if.sv
// inv_mixcolumn_addroundkey_if: ap_ctrl_hs handshake, round inputs and statemt dual-port RAM bus
interface inv_mixcolumn_addroundkey_if;
    logic         ap_start;
    logic         ap_done;
    logic         ap_idle;
    logic         ap_ready;
    logic [3:0]   n;
    logic [127:0] round_key;
    logic [4:0]   statemt_address0;
    logic [4:0]   statemt_address1;
    logic         statemt_ce0;
    logic         statemt_ce1;
    logic         statemt_we0;
    logic         statemt_we1;
    logic [31:0]  statemt_d0;
    logic [31:0]  statemt_d1;
    logic [31:0]  statemt_q0;
    logic [31:0]  statemt_q1;
    modport slave (
        input  ap_start, n, round_key, statemt_q0, statemt_q1,
        output ap_done, ap_idle, ap_ready,
        output statemt_address0, statemt_address1, statemt_ce0, statemt_ce1,
        output statemt_we0, statemt_we1, statemt_d0, statemt_d1
    );
    modport master (
        output ap_start, n, round_key, statemt_q0, statemt_q1,
        input  ap_done, ap_idle, ap_ready,
        input  statemt_address0, statemt_address1, statemt_ce0, statemt_ce1,
        input  statemt_we0, statemt_we1, statemt_d0, statemt_d1
    );
endinterface

// File: rtl/inv_mixcol_column.sv
// inv_mixcol_column: combinational InvMixColumns of one 4-byte column
module inv_mixcol_column
    import aes_dec_pkg::*;
(
    input  col_t a,
    output col_t o
);
    for (genvar i = 0; i < 4; i++) begin : g_row
        assign o[i] = gmul(a[i], 4'he) ^ gmul(a[(i + 1) % 4], 4'hb)
                    ^ gmul(a[(i + 2) % 4], 4'hd) ^ gmul(a[(i + 3) % 4], 4'h9);
    end
endmodule

// File: rtl/inv_mixcolumn_addroundkey.sv
// inv_mixcolumn_addroundkey: in-place AddRoundKey + InvMixColumns over the 16-byte statemt RAM.
// INV_MIXCOL_LAST_ROUND_EN: when defined, captured n==0 bypasses InvMixColumns.
module inv_mixcolumn_addroundkey
    import aes_dec_pkg::*;
(
    input logic ap_clk,
    input logic ap_rst_n,
    inv_mixcolumn_addroundkey_if.slave bus
);
    state_t       state;
    logic [1:0]   col;
    logic [127:0] key_r;
    col_t         a, mix, o;
    logic         lo, hi, acc, wr;
    logic [4:0]   base;
    logic         unused_bits;
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
            col   <= '0;
            key_r <= '0;
            a     <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.ap_start) begin
                    state <= S_RD0;
                    col   <= '0;
                    key_r <= bus.round_key;
                end
                S_RD0: state <= S_RD1;
                S_RD1: begin
                    a[0]  <= bus.statemt_q0[7:0] ^ key_r[127:120];
                    a[1]  <= bus.statemt_q1[7:0] ^ key_r[119:112];
                    state <= S_RDW;
                end
                S_RDW: begin
                    a[2]  <= bus.statemt_q0[7:0] ^ key_r[111:104];
                    a[3]  <= bus.statemt_q1[7:0] ^ key_r[103:96];
                    state <= S_WR0;
                end
                S_WR0: state <= S_WR1;
                // Rotating the key keeps the current column's key bytes on top.
                S_WR1: begin
                    key_r <= {key_r[95:0], key_r[127:96]};
                    col   <= col + 2'd1;
                    state <= (col == 2'd3) ? S_DONE : S_RD0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    inv_mixcol_column u_mix (.a(a), .o(mix));
`ifdef INV_MIXCOL_LAST_ROUND_EN
    logic [3:0] n_r;
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) n_r <= '0;
        else if (state == S_IDLE && bus.ap_start) n_r <= bus.n;
    end
    assign o = (n_r == 4'd0) ? a : mix;
`else
    assign o = mix;
`endif
    assign unused_bits = ^{bus.n, bus.statemt_q0[31:8], bus.statemt_q1[31:8]};
    always_comb begin
        lo   = (state == S_RD0) || (state == S_WR0);
        hi   = (state == S_RD1) || (state == S_WR1);
        acc  = lo || hi;
        wr   = (state == S_WR0) || (state == S_WR1);
        base = {1'b0, col, 2'b00};
        bus.statemt_address0 = acc ? (base | (hi ? 5'd2 : 5'd0)) : 5'd0;
        bus.statemt_address1 = acc ? (base | (hi ? 5'd3 : 5'd1)) : 5'd0;
        bus.statemt_ce0 = acc;
        bus.statemt_ce1 = acc;
        bus.statemt_we0 = wr;
        bus.statemt_we1 = wr;
        bus.statemt_d0 = (state == S_WR0) ? {24'h0, o[0]} : (state == S_WR1) ? {24'h0, o[2]} : 32'h0;
        bus.statemt_d1 = (state == S_WR0) ? {24'h0, o[1]} : (state == S_WR1) ? {24'h0, o[3]} : 32'h0;
        bus.ap_idle  = (state == S_IDLE);
        bus.ap_done  = (state == S_DONE);
        bus.ap_ready = (state == S_DONE);
    end
endmodule

// File: tb/tb_inv_mixcolumn_addroundkey.sv
// tb_inv_mixcolumn_addroundkey: directed + random checks against a GF(2^8) matrix reference model
module tb_inv_mixcolumn_addroundkey;
    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    inv_mixcolumn_addroundkey_if bus ();
    inv_mixcolumn_addroundkey dut (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus));
    always #5 ap_clk = ~ap_clk;

    logic [31:0]  mem [32];
    logic [7:0]   init_img [16];
    logic         load = 1'b0;
    logic [7:0]   img [16];
    logic [7:0]   exp_st [16];
    logic [127:0] kk;
    logic [3:0]   nn;
    int cmp = 0;
    int errs = 0;

    always @(posedge ap_clk) begin
        if (load) for (int i = 0; i < 16; i++) mem[i] <= {24'h0, init_img[i]};
        if (bus.statemt_ce0) begin
            if (bus.statemt_we0) mem[bus.statemt_address0] <= bus.statemt_d0;
            bus.statemt_q0 <= mem[bus.statemt_address0];
        end
        if (bus.statemt_ce1) begin
            if (bus.statemt_we1) mem[bus.statemt_address1] <= bus.statemt_d1;
            bus.statemt_q1 <= mem[bus.statemt_address1];
        end
    end

    function automatic logic [7:0] gf(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p = 16'h0;
        for (int i = 0; i < 8; i++) if (y[i]) p ^= 16'(x) << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h11b << (i - 8);
        return p[7:0];
    endfunction

    function automatic void model();
        logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [7:0] av [4];
        logic [7:0] s;
        bit bypass = 1'b0;
`ifdef INV_MIXCOL_LAST_ROUND_EN
        bypass = (nn == 4'd0);
`endif
        for (int j = 0; j < 4; j++) begin
            for (int c = 0; c < 4; c++) av[c] = img[4*j+c] ^ kk[127-8*(4*j+c) -: 8];
            for (int r = 0; r < 4; r++) begin
                s = 8'h0;
                for (int c = 0; c < 4; c++) s ^= gf(coef[(c - r + 4) % 4], av[c]);
                exp_st[4*j+r] = bypass ? av[r] : s;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        cmp++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic load_img();
        for (int i = 0; i < 16; i++) init_img[i] = img[i];
        load = 1'b1;
        @(posedge ap_clk); #1;
        load = 1'b0;
    endtask

    task automatic set_cols(input logic [31:0] c);
        for (int j = 0; j < 4; j++) for (int i = 0; i < 4; i++) img[4*j+i] = c[31-8*i -: 8];
    endtask

    task automatic check_mem(input string tag, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) chk(tag, mem[k], {24'h0, exp_st[k]});
    endtask

    task automatic run_op(input string tag);
        int lat;
        load_img();
        model();
        bus.ap_start = 1'b1; bus.n = nn; bus.round_key = kk;
        chk({tag, "_idle_pre"}, 32'(bus.ap_idle), 1);
        @(posedge ap_clk); #1;
        bus.ap_start = 1'b0; bus.n = 4'($urandom); bus.round_key = {$urandom, $urandom, $urandom, $urandom};
        chk({tag, "_idle_busy"}, 32'(bus.ap_idle), 0);
        lat = 1;
        while (!bus.ap_done && lat < 60) begin @(posedge ap_clk); #1; lat++; end
        chk({tag, "_latency"}, lat, 21);
        chk({tag, "_ready"}, 32'(bus.ap_ready), 1);
        @(posedge ap_clk); #1;
        chk({tag, "_done_pulse"}, 32'({bus.ap_done, bus.ap_ready}), 0);
        chk({tag, "_idle_post"}, 32'(bus.ap_idle), 1);
        check_mem({tag, "_mem"}, 0, 15);
    endtask

    initial begin
        int w;
        logic [7:0] orig [16];
        bus.ap_start = 1'b0; bus.n = 4'd0; bus.round_key = '0;
        #1;
        chk("rst_idle", 32'(bus.ap_idle), 1);
        chk("rst_done_ready", 32'({bus.ap_done, bus.ap_ready}), 0);
        chk("rst_ce_we", 32'({bus.statemt_ce0, bus.statemt_ce1, bus.statemt_we0, bus.statemt_we1}), 0);
        chk("rst_addr", 32'({bus.statemt_address0, bus.statemt_address1}), 0);
        chk("rst_d", bus.statemt_d0 | bus.statemt_d1, 0);
        #11 ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;

        set_cols(32'h8e4da1bc); kk = '0; nn = 4'd5;
        run_op("basic");
        chk("basic_anchor0", mem[0], 32'hdb);
        chk("basic_anchor15", mem[15], 32'h45);

        set_cols(32'h71b25e43); kk = {128{1'b1}}; nn = 4'd3;
        run_op("keyxor");
        chk("keyxor_anchor", mem[5], 32'h13);

        set_cols(32'h01010101); kk = '0; nn = 4'd7;
        run_op("ones");
        set_cols(32'h00000000); kk = '0; nn = 4'd2;
        run_op("zeros");
        set_cols(32'h8e4da1bc); kk = '0; nn = 4'd0;
        run_op("lastround");

        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < 16; k++) img[k] = 8'($urandom);
            kk = {$urandom, $urandom, $urandom, $urandom};
            nn = (t == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            run_op("random");
        end

        bus.ap_start = 1'b1;
        for (int c = 0; c < 50; c++) begin
            chk("b2b_idle", 32'(bus.ap_idle), 32'(c % 22 == 0));
            chk("b2b_done", 32'(bus.ap_done), 32'(c % 22 == 21));
            chk("b2b_ready", 32'(bus.ap_ready), 32'(c % 22 == 21));
            @(posedge ap_clk); #1;
        end
        bus.ap_start = 1'b0;
        w = 0;
        while (!bus.ap_idle && w < 40) begin @(posedge ap_clk); #1; w++; end
        chk("b2b_drain", 32'(w < 40), 1);

        for (int k = 0; k < 16; k++) begin img[k] = 8'($urandom); orig[k] = img[k]; end
        kk = {$urandom, $urandom, $urandom, $urandom}; nn = 4'd9;
        load_img();
        model();
        bus.ap_start = 1'b1; bus.n = nn; bus.round_key = kk;
        @(posedge ap_clk); #1;
        bus.ap_start = 1'b0;
        repeat (8) begin @(posedge ap_clk); #1; end
        chk("rstmid_in_wr0", 32'({bus.statemt_we0, bus.statemt_address0}), 32'({1'b1, 5'd4}));
        ap_rst_n = 1'b0;
        #1;
        chk("rstmid_idle", 32'(bus.ap_idle), 1);
        chk("rstmid_ce_we", 32'({bus.statemt_ce0, bus.statemt_ce1, bus.statemt_we0, bus.statemt_we1}), 0);
        @(posedge ap_clk); #1;
        chk("rstmid_hold", 32'({bus.statemt_ce0, bus.statemt_ce1, bus.ap_done}), 0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        chk("rstmid_after", 32'({bus.ap_idle, bus.statemt_ce0, bus.statemt_we0}), 32'(3'b100));
        check_mem("rstmid_col0", 0, 3);
        for (int k = 6; k < 16; k++) chk("rstmid_untouched", mem[k], {24'h0, orig[k]});

        for (int k = 0; k < 16; k++) img[k] = 8'($urandom);
        kk = {$urandom, $urandom, $urandom, $urandom}; nn = 4'd1;
        run_op("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule

// File: doc/inv_mixcolumn_addroundkey.md
# inv_mixcolumn_addroundkey

Decryption-side counterpart of the AES MixColumn/AddRoundKey round step. It XORs a 128-bit round key into the 16-byte state and then applies InvMixColumns column by column, in place. The state lives in the shared `statemt` dual-port RAM, and the block is started by the AES decrypt controller through the ap_ctrl_hs handshake.

## Interface
- No parameters; block size fixed at Nb=4 (16 state bytes at statemt addresses 0..15).
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- ap_start  in  1  request; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse when all 16 bytes have been written back.
- ap_idle  out  1  high in IDLE.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- statemt_address0/1  out  5  RAM port 0/1 word address.
- statemt_ce0/1  out  1  RAM port 0/1 enable.
- statemt_we0/1  out  1  RAM port 0/1 write enable.
- statemt_d0/1  out  32  write data; result byte in [7:0], [31:8] zero.
- statemt_q0/1  in  32  read data, valid one cycle after ce; only [7:0] used.
- n  in  4  round number; captured at start.
- round_key  in  128  round key; byte k = round_key[127-8k -: 8]; captured at start.

## Operation
- State byte index k = i + 4*j (row i, column j), stored at address k.
- Per byte: a_i = statemt[k] ^ key[k].
- Per column: InvMixColumns over GF(2^8) with polynomial 0x11b:
  - o0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3.
  - o1, o2 and o3 use the same coefficients, rotated one position per row.
- FSM states: IDLE, RD0, RD1, RDW, WR0, WR1, DONE.
  - IDLE: on ap_start, capture n and round_key, set col=0, go to RD0.
  - RD0: read addresses 4col+0 and 4col+1 on ports 0 and 1. Go to RD1.
  - RD1: capture bytes 0 and 1 from q0/q1; read 4col+2 and 4col+3. Go to RDW.
  - RDW: capture bytes 2 and 3. Go to WR0.
  - WR0: write o0 and o1 to 4col+0 and 4col+1, computed from the stable byte registers. Go to WR1.
  - WR1: write o2 and o3 to 4col+2 and 4col+3. If col==3 go to DONE; else col++ and go to RD0.
  - DONE: pulse ap_done and ap_ready. Go to IDLE.
- ce is high only in RD0, RD1, WR0 and WR1; we is high only in WR0 and WR1. Both ports carry the same enables.

## Timing
- Reset values: ap_done=0, ap_ready=0, ap_idle=1, all ce/we=0, addresses=0, d=0, FSM=IDLE, col=0.
- Start is accepted in cycle 0 (IDLE with ap_start=1). Columns occupy cycles 1..20 at 5 cycles each. DONE is cycle 21, so ap_done rises 21 cycles after acceptance.
- ap_idle drops in cycle 1 and returns in cycle 22.
- Back-to-back: with ap_start held, the next start is accepted in cycle 22. ap_start is ignored in every non-IDLE state.
- Changes on n or round_key after acceptance have no effect on the current operation.
- Reset mid-operation: FSM goes to IDLE immediately and all enables drop asynchronously. Writes already issued persist; no further accesses occur.
- Reads and writes never overlap, so there is no read-after-write hazard. The RAM is treated as read-first or write-first indifferently.

## Configuration
- `INV_MIXCOL_LAST_ROUND_EN`:
  - Defined: when captured n==0 (final decryption round), InvMixColumns is bypassed and o_i = a_i (pure AddRoundKey). Cycle count is unchanged.
  - Undefined: InvMixColumns is always applied and n is unused.

## Structure
- Package `aes_dec_pkg`:
  - FSM state enum.
  - Functions xtime (polynomial 0x11b) and gmul for constants 09, 0b, 0d, 0e.
  - Byte and column typedefs.
- Sub-module `inv_mixcol_column`: purely combinational 4-byte InvMixColumns, instantiated once and shared across columns.

## Test plan
- Basic InvMixColumns: key=0, n=5, every column = 8e 4d a1 bc → every column reads back db 13 53 45; ap_done pulses exactly once, 21 cycles after start.
- Key XOR: state columns 71 b2 5e 43, key bytes all ff → columns db 13 53 45.
- Identity column: state all 01, key 0 → state all 01. State all 00, key 0 → all 00.
- Last round with `INV_MIXCOL_LAST_ROUND_EN` defined: n=0, state 8e 4d a1 bc ×4, key 0 → unchanged. Same stimulus without the macro → db 13 53 45.
- Handshake: ap_start held high for 50 cycles → starts accepted at cycles 0 and 22; ap_done and ap_ready are coincident single-cycle pulses; ap_idle low exactly during cycles 1..21 of each run.
- Reset mid-op: drive ap_rst_n low during WR0 of column 1 → ap_idle=1 immediately, ce/we=0; addresses 4..5 may be written, addresses 6..15 unchanged. A following start completes normally.
